seven_seg_scan_driver: RTL
==========================

// Module: seven_seg_scan_driver
// PURPOSE
//  Downstream display stage of the RPN calculator: consumes the 16-bit ToDisplay word and the 3-bit
//  FSM Status and drives an 8-digit common-anode 7-segment display by time multiplexing.
//  Shows the value in hex (4 digits) or unsigned decimal (5 digits), and Status on digit 7.
//  Decimal digits come from an iterative double-dabble converter, so no wide combinational divider.
// PARAMETERS
//  SCAN_DIV  100_000  clk cycles each digit stays lit (~1 kHz per digit at 100 MHz); must be >= 2
// PORTS
//  clk       in   1   system clock, all state on rising edge
//  reset     in   1   asynchronous, active-high; clears all state
//  value     in   16  word to show (ToDisplay)
//  status    in   3   FSM state code, shown as digit 0-7 on digit 7
//  dec_mode  in   1   0 = hex, 1 = unsigned decimal
//  blank_lz  in   1   1 = blank leading zeros (the least significant digit always shows)
//  anodes    out  8   digit enables, active low, bit i = digit i (digit 0 = rightmost)
//  segments  out  7   {g,f,e,d,c,b,a}, active low
//  dp        out  1   decimal point, active low, always 1 (off) after reset
//  busy      out  1   1 while the BCD conversion runs
// BEHAVIOUR
//  Reset values: anodes=8'hFF, segments=7'h7F, dp=1, busy=0. Scan counter, digit index, BCD register,
//   shadow value and FSM state all clear to 0. The FSM resets to IDLE. The first digit lights one
//   cycle after reset is released.
//  Scan: a counter runs 0..SCAN_DIV-1. At wrap, the digit index advances 0->1->...->7->0.
//   anodes and segments are registered, so both update on the same edge and never glitch.
//  Digit content:
//   - hex mode: digits 0-3 = value nibbles [3:0]..[15:12]; digits 4-6 blank.
//   - dec mode: digits 0-4 = BCD ones..ten-thousands; digits 5-6 blank.
//   - digit 7 = status (0-7) in both modes.
//   - blank means segments=7'h7F, anode still driven.
//  Leading-zero blanking: with blank_lz=1, a zero digit is blanked when every higher value digit is
//   also zero. Digit 0 is never blanked. Digit 7 is unaffected.
//  Font: the standard 0-F hex font (A b C d E F). Examples: 0=7'h40, 8=7'h00, F=7'h0E.
//  Converter FSM states are IDLE, SHIFT and DONE.
//   - IDLE: if value != shadow, or the shadow is invalid, latch value into the shadow, load the
//     shift register and go to SHIFT. busy goes high the next cycle.
//   - SHIFT: 16 iterations. Each iteration first adds 3 to every BCD nibble >= 5, then shifts left 1.
//   - DONE: copy the 20-bit result to the display BCD register in one cycle. busy goes low, then
//     return to IDLE.
//   - Latency from a value change to a new BCD register: 18 cycles (1 load + 16 shift + 1 done).
//  The display BCD register holds the previous result during conversion (no partial digits shown).
//  A value change during SHIFT is ignored. IDLE re-compares after DONE and restarts if needed, so the
//   last stable value is always shown eventually.
//  The converter runs in both modes, so switching to dec_mode shows a correct result at once.
//   Hex digits read value directly, combinationally, through the output register.
//  Reset mid-conversion aborts it: the BCD register clears to 0 and the shadow is invalid. After
//   reset the current value converts again.
// TESTING
//  1 Hold reset, then release -> anodes=8'hFF, segments=7'h7F, busy=0 while reset is held;
//    anodes=8'hFE one cycle after release.
//  2 SCAN_DIV=4, hex, value=16'hBEEF, status=3 -> anodes step FE,FD,...,7F every 4 cycles.
//    Segments: F,E,E,b, blank x3, then 3 (7'h30).
//  3 dec, value=16'd65535 -> busy high for exactly 17 cycles, then BCD digits 5,3,5,5,6 (ones first).
//    The display shows "65535".
//  4 dec, value 1234, changed to 42 five cycles into SHIFT -> 1234 is shown first, then an automatic
//    restart. Final "00042"; with blank_lz=1 only digits 0-1 lit ("42"), digits 2-4 blank.
//  5 Reset asserted mid-SHIFT with value=16'd999 -> all outputs return to reset values at once.
//    After release, "00999" is shown within 18 cycles.
//  6 hex, value=0, blank_lz=1 -> only digit 0 shows "0" (7'h40); digits 1-3 blank; digit 7 shows status.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_driver
// Brief    : 8-digit multiplexed 7-segment driver, hex or decimal (double dabble).
// Revision : 1.0
// ============================================================================
module seven_seg_scan_driver #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [2:0]  status,
    input  logic        dec_mode,
    input  logic        blank_lz,
    output logic [7:0]  anodes,
    output logic [6:0]  segments,
    output logic        dp,
    output logic        busy
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0] c_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    logic [CNT_W-1:0] r_scan_cnt;
    logic [2:0]       r_digit;
    logic [7:0]       r_anodes;
    logic [6:0]       r_segments;
    logic             r_dp;

    state_t           r_state;
    logic [15:0]      r_shadow;
    logic             r_shadow_vld;
    logic [35:0]      r_shift;
    logic [3:0]       r_iter;
    logic [19:0]      r_bcd;
    logic             r_busy;

    logic [19:0]      w_adj;
    logic [3:0]       w_vals [8];
    logic [7:0]       w_valid;
    logic [7:0]       w_zero_up;
    logic [6:0]       w_seg;

    function automatic logic [6:0] f_font(input logic [3:0] n);
        case (n)
            4'h0: f_font = 7'h40;  4'h1: f_font = 7'h79;
            4'h2: f_font = 7'h24;  4'h3: f_font = 7'h30;
            4'h4: f_font = 7'h19;  4'h5: f_font = 7'h12;
            4'h6: f_font = 7'h02;  4'h7: f_font = 7'h78;
            4'h8: f_font = 7'h00;  4'h9: f_font = 7'h10;
            4'hA: f_font = 7'h08;  4'hB: f_font = 7'h03;
            4'hC: f_font = 7'h46;  4'hD: f_font = 7'h21;
            4'hE: f_font = 7'h06;  default: f_font = 7'h0E;
        endcase
    endfunction

    // Double-dabble correction applied to every BCD nibble before each shift
    for (genvar g = 0; g < 5; g++) begin : g_adj
        assign w_adj[4*g +: 4] = (r_shift[16+4*g +: 4] >= 4'd5) ?
                                 r_shift[16+4*g +: 4] + 4'd3 : r_shift[16+4*g +: 4];
    end

    always_comb begin : comb_digit
        logic v_run;
        for (int k = 0; k < 8; k++) begin
            w_vals[k] = 4'h0;
        end
        if (dec_mode) begin
            w_valid = 8'h1F;
            for (int k = 0; k < 5; k++) begin
                w_vals[k] = r_bcd[4*k +: 4];
            end
        end else begin
            w_valid = 8'h0F;
            for (int k = 0; k < 4; k++) begin
                w_vals[k] = value[4*k +: 4];
            end
        end
        // w_zero_up[k]: this digit and every higher one are zero
        v_run = 1'b1;
        for (int k = 7; k >= 0; k--) begin
            v_run        = v_run && (w_vals[k] == 4'h0);
            w_zero_up[k] = v_run;
        end
        w_seg = c_BLANK;
        if (r_digit == 3'd7) begin
            w_seg = f_font({1'b0, status});
        end else if (w_valid[r_digit]) begin
            if (blank_lz && (r_digit != 3'd0) && w_zero_up[r_digit]) begin
                w_seg = c_BLANK;
            end else begin
                w_seg = f_font(w_vals[r_digit]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_digit    <= 3'd0;
            r_anodes   <= 8'hFF;
            r_segments <= c_BLANK;
            r_dp       <= 1'b1;
        end else begin
            if (r_scan_cnt == c_CNT_LAST) begin
                r_scan_cnt <= '0;
                r_digit    <= r_digit + 3'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_anodes   <= ~(8'b1 << r_digit);
            r_segments <= w_seg;
            r_dp       <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_shadow     <= 16'h0;
            r_shadow_vld <= 1'b0;
            r_shift      <= 36'h0;
            r_iter       <= 4'd0;
            r_bcd        <= 20'h0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_shadow_vld || (value != r_shadow)) begin
                        r_shadow     <= value;
                        r_shadow_vld <= 1'b1;
                        r_shift      <= {20'h0, value};
                        r_iter       <= 4'd0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_shift <= {w_adj[18:0], r_shift[15:0], 1'b0};
                    r_iter  <= r_iter + 4'd1;
                    if (r_iter == 4'd15) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_bcd   <= r_shift[35:16];
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign anodes   = r_anodes;
    assign segments = r_segments;
    assign dp       = r_dp;
    assign busy     = r_busy;

endmodule
`default_nettype wire
